// File: rtl/spi_frame_scheduler_pkg.sv
// Shared types and widths for the SPI frame scheduler: FSM state encoding and byte/word sizes.
package spi_sched_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SEND_HI,
      SEND_LO,
      HOLD,
      GAP
   } sched_state_e;

endpackage

// File: rtl/spi_frame_scheduler_if.sv
// Requester-side and byte-core-side signals of the SPI frame scheduler, bundled in one interface.
interface spi_frame_scheduler_if
   import spi_sched_pkg::*;
#(
   parameter int NUM_REQ = 2
);

   logic [NUM_REQ-1:0]        i_req;
   logic [NUM_REQ*WORD_W-1:0] i_data;
   logic [NUM_REQ-1:0]        o_ack;
   logic [NUM_REQ-1:0]        o_done;
   logic                      o_tx_start;
   logic [BYTE_W-1:0]         o_tx_byte;
   logic                      i_tx_done;
   logic [BYTE_W-1:0]         i_rx_byte;
   logic                      o_ss;
   logic [WORD_W-1:0]         o_rx_data;
   logic                      o_rx_valid;
   logic                      o_busy;

   modport master (
      input  i_req, i_data, i_tx_done, i_rx_byte,
      output o_ack, o_done, o_tx_start, o_tx_byte, o_ss, o_rx_data, o_rx_valid, o_busy
   );

   modport slave (
      output i_req, i_data, i_tx_done, i_rx_byte,
      input  o_ack, o_done, o_tx_start, o_tx_byte, o_ss, o_rx_data, o_rx_valid, o_busy
   );

endinterface

// File: rtl/spi_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr, wrapping at NUM_REQ-1.
module rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic [IDX_W:0] pos;
   logic           found;

   // One spare bit on pos lets ptr+i exceed NUM_REQ-1 before the wrap subtract.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(i);
         if (pos >= (IDX_W+1)'(NUM_REQ)) begin
            pos = pos - (IDX_W+1)'(NUM_REQ);
         end
         if (en && !found && req[pos[IDX_W-1:0]]) begin
            found                   = 1'b1;
            grant[pos[IDX_W-1:0]]   = 1'b1;
            grant_idx               = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/spi_frame_scheduler.sv
// Round-robin scheduler framing each requester's 16-bit word as two bytes on a shared SPI byte core,
// with a minimum slave-select-high gap between frames.
module spi_frame_scheduler
   import spi_sched_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int GAP_CYCLES = 4
) (
   input logic                   clk,
   input logic                   reset_n,
   spi_frame_scheduler_if.master bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   sched_state_e      state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  gnt_q, gnt_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [BYTE_W-1:0] rx_hi_q, rx_hi_d;
   logic [BYTE_W-1:0] rx_lo_q, rx_lo_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic              tx_start_q, tx_start_d;
   logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
   logic              ss_q, ss_d;
   logic [WORD_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              busy_q, busy_d;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arbiter (
      .req       (bus.i_req),
      .ptr       (ptr_q),
      .en        (state_q == IDLE),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Next-state and next-output logic; every output is a flop fed from here.
   // ptr holds the index where the next search starts, i.e. last grant + 1.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      word_d     = word_q;
      rx_hi_d    = rx_hi_q;
      rx_lo_d    = rx_lo_q;
      gap_d      = gap_q;
      ack_d      = '0;
      done_d     = '0;
      tx_start_d = 1'b0;
      tx_byte_d  = tx_byte_q;
      ss_d       = ss_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (|grant) begin
               ack_d = grant;
               gnt_d = grant_idx;
               for (int k = 0; k < NUM_REQ; k++) begin
                  if (grant[k]) begin
                     word_d = bus.i_data[k*WORD_W +: WORD_W];
                  end
               end
               ptr_d   = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
               ss_d    = 1'b0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            tx_start_d = 1'b1;
            tx_byte_d  = word_q[WORD_W-1:BYTE_W];
            state_d    = SEND_HI;
         end
         SEND_HI: begin
            if (bus.i_tx_done) begin
               rx_hi_d    = bus.i_rx_byte;
               tx_start_d = 1'b1;
               tx_byte_d  = word_q[BYTE_W-1:0];
               state_d    = SEND_LO;
            end
         end
         SEND_LO: begin
            if (bus.i_tx_done) begin
               rx_lo_d = bus.i_rx_byte;
               state_d = HOLD;
            end
         end
         HOLD: begin
            rx_data_d     = {rx_hi_q, rx_lo_q};
            rx_valid_d    = 1'b1;
            done_d[gnt_q] = 1'b1;
            ss_d          = 1'b1;
            gap_d         = GAP_W'(GAP_CYCLES-1);
            state_d       = GAP;
         end
         GAP: begin
            if (gap_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset forces slave select high immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         gnt_q      <= '0;
         word_q     <= '0;
         rx_hi_q    <= '0;
         rx_lo_q    <= '0;
         gap_q      <= '0;
         ack_q      <= '0;
         done_q     <= '0;
         tx_start_q <= 1'b0;
         tx_byte_q  <= '0;
         ss_q       <= 1'b1;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         word_q     <= word_d;
         rx_hi_q    <= rx_hi_d;
         rx_lo_q    <= rx_lo_d;
         gap_q      <= gap_d;
         ack_q      <= ack_d;
         done_q     <= done_d;
         tx_start_q <= tx_start_d;
         tx_byte_q  <= tx_byte_d;
         ss_q       <= ss_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.o_ack      = ack_q;
   assign bus.o_done     = done_q;
   assign bus.o_tx_start = tx_start_q;
   assign bus.o_tx_byte  = tx_byte_q;
   assign bus.o_ss       = ss_q;
   assign bus.o_rx_data  = rx_data_q;
   assign bus.o_rx_valid = rx_valid_q;
   assign bus.o_busy     = busy_q;

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Scoreboard bench for spi_frame_scheduler: requester and byte-core models feed expectation queues
// that are popped as the scheduler produces acks, tx bytes, received words and done pulses.
module tb_spi_frame_scheduler;
   import spi_sched_pkg::*;

   localparam int NUM_REQ    = 2;
   localparam int GAP_CYCLES = 4;
   localparam int CORE_LAT   = 3;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   spi_frame_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

   spi_frame_scheduler #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int tests = 0;
   int fails = 0;
   int cycle = 0;

   int          exp_ack[$];
   logic [7:0]  exp_tx[$];
   logic [15:0] exp_rx[$];
   int          exp_done[$];
   logic [7:0]  echo_q[$];

   int remaining[NUM_REQ];
   int ack_count[NUM_REQ];
   int ack_cycle[NUM_REQ];
   int done_total      = 0;
   int done_cycle      = 0;
   int tx_start_total  = 0;
   int rx_valid_total  = 0;
   int busy_fall_cycle = 0;
   int core_timer      = 0;
   int ss_high         = 0;
   bit had_frame       = 1'b0;
   bit prev_busy       = 1'b0;
   bit stray_req       = 1'b0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic expectFrame(input int idx, input logic [15:0] word, input logic [7:0] hi, input logic [7:0] lo);
      exp_ack.push_back(idx);
      exp_tx.push_back(word[15:8]);
      exp_tx.push_back(word[7:0]);
      echo_q.push_back(hi);
      echo_q.push_back(lo);
      exp_rx.push_back({hi, lo});
      exp_done.push_back(idx);
   endtask

   task automatic applyStimulus(input int idx, input logic [15:0] word, input logic [7:0] hi, input logic [7:0] lo);
      bus.i_data[idx*16 +: 16] = word;
      bus.i_req[idx]           = 1'b1;
      expectFrame(idx, word, hi, lo);
   endtask

   function automatic int pendingCount();
      return exp_ack.size() + exp_tx.size() + exp_rx.size() + exp_done.size();
   endfunction

   task automatic drain(input int budget);
      int n = 0;
      while ((pendingCount() != 0 || bus.o_busy || bus.i_req != '0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_pending", pendingCount(), 0);
   endtask

   task automatic waitDone(input int target, input int budget);
      int n = 0;
      while (done_total < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("wait_done", done_total >= target, 1);
   endtask

   task automatic waitTx(input int target, input int budget);
      int n = 0;
      while (tx_start_total < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("wait_tx", tx_start_total >= target, 1);
   endtask

   // Requester, byte-core and output monitor, all evaluated on the falling edge.
   initial begin
      bus.i_req     = '0;
      bus.i_data    = '0;
      bus.i_tx_done = 1'b0;
      bus.i_rx_byte = '0;
      forever begin
         @(negedge clk);
         bus.i_tx_done = 1'b0;
         if (!reset_n) begin
            core_timer = 0;
            had_frame  = 1'b0;
            ss_high    = 0;
            prev_busy  = 1'b0;
         end else begin
            if (core_timer > 0) begin
               core_timer--;
               if (core_timer == 0) begin
                  bus.i_tx_done = 1'b1;
                  bus.i_rx_byte = (echo_q.size() > 0) ? echo_q.pop_front() : 8'hEE;
                  checkOutput("ss_low_at_done", bus.o_ss, 0);
               end
            end
            if (stray_req && !bus.i_tx_done) begin
               bus.i_tx_done = 1'b1;
               bus.i_rx_byte = 8'hFF;
               stray_req     = 1'b0;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
               if (bus.o_ack[k]) begin
                  ack_count[k]++;
                  ack_cycle[k] = cycle;
                  if (exp_ack.size() == 0) checkOutput("ack_unexpected", bus.o_ack, '0);
                  else                     checkOutput("ack_index", k, exp_ack.pop_front());
                  checkOutput("ack_ss_low", bus.o_ss, 0);
                  if (remaining[k] > 0) remaining[k]--;
                  else                  bus.i_req[k] = 1'b0;
               end
            end
            if (bus.o_tx_start) begin
               tx_start_total++;
               if (exp_tx.size() == 0) checkOutput("tx_unexpected", bus.o_tx_start, 0);
               else                    checkOutput("tx_byte", bus.o_tx_byte, exp_tx.pop_front());
               checkOutput("tx_ss_low", bus.o_ss, 0);
               core_timer = CORE_LAT;
            end
            if (bus.o_rx_valid) begin
               rx_valid_total++;
               if (exp_rx.size() == 0) checkOutput("rx_unexpected", bus.o_rx_valid, 0);
               else                    checkOutput("rx_data", bus.o_rx_data, exp_rx.pop_front());
            end
            for (int k = 0; k < NUM_REQ; k++) begin
               if (bus.o_done[k]) begin
                  done_total++;
                  done_cycle = cycle;
                  had_frame  = 1'b1;
                  if (exp_done.size() == 0) checkOutput("done_unexpected", bus.o_done, '0);
                  else                      checkOutput("done_index", k, exp_done.pop_front());
                  checkOutput("done_ss_high", bus.o_ss, 1);
                  checkOutput("done_rx_valid", bus.o_rx_valid, 1);
               end
            end
            if (bus.o_ss) begin
               ss_high++;
            end else begin
               if (ss_high > 0 && had_frame) checkOutput("ss_gap_min", ss_high >= GAP_CYCLES + 1, 1);
               ss_high = 0;
            end
            if (prev_busy && !bus.o_busy) busy_fall_cycle = cycle;
            prev_busy = bus.o_busy;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d failed so far", fails);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int base1;
      int gdone;

      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      @(negedge clk);
      checkOutput("rst_ss", bus.o_ss, 1);
      checkOutput("rst_ack", bus.o_ack, 0);
      checkOutput("rst_done", bus.o_done, 0);
      checkOutput("rst_tx_start", bus.o_tx_start, 0);
      checkOutput("rst_rx_valid", bus.o_rx_valid, 0);
      checkOutput("rst_busy", bus.o_busy, 0);
      checkOutput("rst_tx_byte", bus.o_tx_byte, 8'h00);
      checkOutput("rst_rx_data", bus.o_rx_data, 16'h0000);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Contention: both held for two frames each; pointer 0 after reset gives 0,1,0,1.
      remaining[0] = 1;
      remaining[1] = 1;
      applyStimulus(0, 16'h0001, 8'h11, 8'h81);
      applyStimulus(1, 16'h0002, 8'h12, 8'h82);
      expectFrame(0, 16'h0001, 8'h13, 8'h83);
      expectFrame(1, 16'h0002, 8'h14, 8'h84);
      drain(400);
      checkOutput("cont_ack0", ack_count[0], 2);
      checkOutput("cont_ack1", ack_count[1], 2);

      // Single frame.
      base = done_total;
      applyStimulus(0, 16'h1A2B, 8'hC3, 8'h5D);
      drain(200);
      checkOutput("single_done_count", done_total - base, 1);
      checkOutput("single_rx_hold", bus.o_rx_data, 16'hC35D);

      // Gap enforcement: req1 raised while the gap is running.
      applyStimulus(0, 16'h3C4D, 8'hA1, 8'hA2);
      waitDone(done_total + 1, 200);
      gdone = done_cycle;
      applyStimulus(1, 16'hBEEF, 8'hB1, 8'hB2);
      drain(200);
      checkOutput("gap_ack_delay", ack_cycle[1] - gdone, GAP_CYCLES + 1);

      // Stray done in IDLE.
      base = rx_valid_total;
      stray_req = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("stray_idle_busy", bus.o_busy, 0);
      checkOutput("stray_idle_rx", rx_valid_total - base, 0);

      // Stray done in GAP must not disturb the countdown.
      applyStimulus(0, 16'h5566, 8'h21, 8'h22);
      waitDone(done_total + 1, 200);
      gdone = done_cycle;
      stray_req = 1'b1;
      drain(200);
      checkOutput("stray_gap_busy_len", busy_fall_cycle - gdone, GAP_CYCLES);
      checkOutput("stray_gap_rx", rx_valid_total - base, 1);

      // Withdrawn request: req1 pulses once while busy.
      base1 = ack_count[1];
      applyStimulus(0, 16'h7788, 8'h31, 8'h32);
      waitTx(tx_start_total + 1, 100);
      bus.i_req[1] = 1'b1;
      @(negedge clk);
      bus.i_req[1] = 1'b0;
      drain(200);
      repeat (GAP_CYCLES + 4) @(negedge clk);
      checkOutput("withdrawn_ack1", ack_count[1] - base1, 0);

      // Reset during SEND_LO, then both requesters pending: pointer must restart at 0.
      applyStimulus(0, 16'h9ABC, 8'h41, 8'h42);
      waitTx(tx_start_total + 2, 100);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("rst_mid_ss", bus.o_ss, 1);
      checkOutput("rst_mid_busy", bus.o_busy, 0);
      base = done_total;
      exp_ack.delete();
      exp_tx.delete();
      exp_rx.delete();
      exp_done.delete();
      echo_q.delete();
      remaining[0] = 0;
      remaining[1] = 0;
      applyStimulus(0, 16'hD00D, 8'h51, 8'h52);
      applyStimulus(1, 16'hF00F, 8'h61, 8'h62);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      drain(400);
      checkOutput("rst_done_count", done_total - base, 2);
      checkOutput("rst_rx_last", bus.o_rx_data, 16'h6162);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
